// File: rtl/gb_wr_arbiter_if.sv
// rtl/gb_wr_arbiter_if.sv - global_buffer write-port bundle: loader, core writeback and merged output
interface gb_wr_arbiter_if #(
  parameter int K_CHANNELS = 6,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8
);
  logic [ADDR_W-1:0]            cfg_write_base_addr;
  logic                         ld_valid;
  logic                         ld_ready;
  logic [ADDR_W-1:0]            ld_addr;
  logic [DATA_W-1:0]            ld_data;
  logic [K_CHANNELS-1:0]        core_wr_en;
  logic                         core_ready;
  logic [K_CHANNELS*ADDR_W-1:0] core_addr;
  logic [K_CHANNELS*DATA_W-1:0] core_data;
  logic [K_CHANNELS-1:0]        gb_wr_en;
  logic [K_CHANNELS*ADDR_W-1:0] gb_wr_addr;
  logic [K_CHANNELS*DATA_W-1:0] gb_wr_data;
  logic                         arb_busy;

  modport master (
    output cfg_write_base_addr, ld_valid, ld_addr, ld_data, core_wr_en, core_addr, core_data,
    input  ld_ready, core_ready, gb_wr_en, gb_wr_addr, gb_wr_data, arb_busy
  );

  modport slave (
    input  cfg_write_base_addr, ld_valid, ld_addr, ld_data, core_wr_en, core_addr, core_data,
    output ld_ready, core_ready, gb_wr_en, gb_wr_addr, gb_wr_data, arb_busy
  );
endinterface

// File: rtl/gb_wr_arbiter.sv
// rtl/gb_wr_arbiter.sv - alternating loader/core arbiter for the global_buffer write port
// Optional GB_ARB_STATS_EN adds loader-stall and core-full cycle counters.
module gb_wr_arbiter #(
  parameter int K_CHANNELS = 6,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_async_n,
  gb_wr_arbiter_if.slave bus
`ifdef GB_ARB_STATS_EN
  ,
  input  logic          stat_clr,
  output logic [31:0]   stat_ld_stall,
  output logic [31:0]   stat_core_full
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AW    = K_CHANNELS * ADDR_W;
  localparam int DW    = K_CHANNELS * DATA_W;

  typedef enum logic {
    GRANT_CORE   = 1'b0,
    GRANT_LOADER = 1'b1
  } grant_e;

  grant_e                  last_grant;
  grant_e                  last_grant_nxt;
  logic                    grant_ld;
  logic                    grant_core;
  logic                    ld_ready_c;

  logic [K_CHANNELS-1:0]   mem_en   [FIFO_DEPTH];
  logic [AW-1:0]           mem_addr [FIFO_DEPTH];
  logic [DW-1:0]           mem_data [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic                    fifo_nempty;
  logic                    core_ready_c;
  logic                    push;
  logic [AW-1:0]           push_addr;

  logic [K_CHANNELS-1:0]   wr_en_q;
  logic [AW-1:0]           wr_addr_q;
  logic [DW-1:0]           wr_data_q;

  assign fifo_nempty  = (count != '0);
  assign core_ready_c = (count < CNT_W'(FIFO_DEPTH));
  assign push         = core_ready_c && (|bus.core_wr_en);

  // Base is folded in at push so a later base change never affects queued entries.
  always_comb begin
    push_addr = '0;
    for (int k = 0; k < K_CHANNELS; k++) begin
      push_addr[k*ADDR_W +: ADDR_W] = bus.core_addr[k*ADDR_W +: ADDR_W] + bus.cfg_write_base_addr;
    end
  end

  always_comb begin
    last_grant_nxt = last_grant;
    grant_ld       = 1'b0;
    grant_core     = 1'b0;
    ld_ready_c     = !(fifo_nempty && (last_grant == GRANT_LOADER));
    if (bus.ld_valid && (!fifo_nempty || (last_grant == GRANT_CORE))) begin
      grant_ld       = 1'b1;
      last_grant_nxt = GRANT_LOADER;
    end else if (fifo_nempty) begin
      grant_core     = 1'b1;
      last_grant_nxt = GRANT_CORE;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      last_grant <= GRANT_CORE;
    end else begin
      last_grant <= last_grant_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_en[wr_ptr]   <= bus.core_wr_en;
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= bus.core_data;
    end
  end

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (grant_core) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CNT_W'(push) - CNT_W'(grant_core);
    end
  end

  // Address/data hold their last value when nothing is granted; only the enables drop.
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (grant_ld) begin
      wr_en_q   <= K_CHANNELS'(1'b1);
      wr_addr_q <= AW'(bus.ld_addr);
      wr_data_q <= DW'(bus.ld_data);
    end else if (grant_core) begin
      wr_en_q   <= mem_en[rd_ptr];
      wr_addr_q <= mem_addr[rd_ptr];
      wr_data_q <= mem_data[rd_ptr];
    end else begin
      wr_en_q   <= '0;
    end
  end

  assign bus.ld_ready   = ld_ready_c;
  assign bus.core_ready = core_ready_c;
  assign bus.gb_wr_en   = wr_en_q;
  assign bus.gb_wr_addr = wr_addr_q;
  assign bus.gb_wr_data = wr_data_q;
  assign bus.arb_busy   = fifo_nempty || (|wr_en_q);

`ifdef GB_ARB_STATS_EN
  logic ld_stall_evt;
  logic core_full_evt;

  assign ld_stall_evt  = bus.ld_valid && !ld_ready_c;
  assign core_full_evt = (|bus.core_wr_en) && !core_ready_c;

  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      stat_ld_stall  <= '0;
      stat_core_full <= '0;
    end else if (stat_clr) begin
      stat_ld_stall  <= '0;
      stat_core_full <= '0;
    end else begin
      if (ld_stall_evt && (stat_ld_stall != 32'hFFFF_FFFF)) begin
        stat_ld_stall <= stat_ld_stall + 32'd1;
      end
      if (core_full_evt && (stat_core_full != 32'hFFFF_FFFF)) begin
        stat_core_full <= stat_core_full + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_gb_wr_arbiter.sv
// tb/tb_gb_wr_arbiter.sv - directed self-checking bench for gb_wr_arbiter
module tb_gb_wr_arbiter;
  localparam int K  = 6;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst_async_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   acc_q[$];
  int   n_acc;
  int   n_out;
  int   tag;
  logic [DW-1:0]   nb;
  logic [K*AW-1:0] exp_addr;

  always #5 clk = ~clk;

  gb_wr_arbiter_if #(.K_CHANNELS(K), .ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef GB_ARB_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_ld_stall;
  logic [31:0] stat_core_full;
`endif

  gb_wr_arbiter #(.K_CHANNELS(K), .ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(FD)) dut (
    .clk            (clk),
    .rst_async_n    (rst_async_n),
    .bus            (bus)
`ifdef GB_ARB_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_ld_stall  (stat_ld_stall),
    .stat_core_full (stat_core_full)
`endif
  );

  task automatic chk(input string tag_s, input logic [127:0] obs, input logic [127:0] exp_v);
    n_tests++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag_s, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cfg_write_base_addr = '0;
    bus.ld_valid   = 1'b0;
    bus.ld_addr    = '0;
    bus.ld_data    = '0;
    bus.core_wr_en = '0;
    bus.core_addr  = '0;
    bus.core_data  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_async_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_async_n = 1'b1;
    step();
  endtask

  function automatic logic [K*AW-1:0] lane_addr(input logic [AW-1:0] base, input int incr);
    logic [K*AW-1:0] v;
    v = '0;
    for (int k = 0; k < K; k++) v[k*AW +: AW] = base + AW'(k * incr);
    return v;
  endfunction

  // Drive one cycle of simultaneous loader request and core push tagged with n.
  task automatic drive_contention(input int n);
    nb = DW'(n);
    bus.ld_valid   = 1'b1;
    bus.ld_addr    = AW'(16'h0200 + n);
    bus.ld_data    = DW'(8'h80 + n);
    bus.core_wr_en = 6'h3f;
    bus.core_addr  = '0;
    bus.core_data  = {K{nb}};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_async_n = 1'b0;
    #1;
    chk("rst_en_async", bus.gb_wr_en, 0);
    do_reset();
    chk("rst_en", bus.gb_wr_en, 0);
    chk("rst_addr", bus.gb_wr_addr, 0);
    chk("rst_busy", bus.arb_busy, 0);
    chk("rst_ld_ready", bus.ld_ready, 1);
    chk("rst_core_ready", bus.core_ready, 1);

    // 1: loader only
    bus.ld_valid = 1'b1; bus.ld_addr = 16'd0; bus.ld_data = 8'd11;
    chk("t1_ld_ready", bus.ld_ready, 1);
    step();
    chk("t1_en0", bus.gb_wr_en, 6'b000001);
    chk("t1_addr0", bus.gb_wr_addr, 0);
    chk("t1_data0", bus.gb_wr_data, 8'd11);
    bus.ld_addr = 16'd1; bus.ld_data = 8'd22;
    step();
    chk("t1_en1", bus.gb_wr_en, 6'b000001);
    chk("t1_data1", bus.gb_wr_data, 8'd22);
    bus.ld_addr = 16'd2; bus.ld_data = 8'd33;
    step();
    chk("t1_en2", bus.gb_wr_en, 6'b000001);
    chk("t1_addr2", bus.gb_wr_addr, 16'd2);
    chk("t1_data2", bus.gb_wr_data, 8'd33);
    bus.ld_valid = 1'b0;
    step();
    chk("t1_idle_en", bus.gb_wr_en, 0);
    chk("t1_hold_addr", bus.gb_wr_addr, 16'd2);
    chk("t1_idle_busy", bus.arb_busy, 0);

    // 2: core only, two-cycle latency with base applied
    bus.cfg_write_base_addr = 16'h0100;
    bus.core_wr_en = 6'h3f;
    bus.core_addr  = lane_addr(16'h0005, 1);
    bus.core_data  = {8'h65, 8'h64, 8'h63, 8'h62, 8'h61, 8'h60};
    step();
    bus.core_wr_en = '0;
    chk("t2_en_push", bus.gb_wr_en, 0);
    chk("t2_busy_q", bus.arb_busy, 1);
    step();
    exp_addr = lane_addr(16'h0105, 1);
    chk("t2_en", bus.gb_wr_en, 6'h3f);
    chk("t2_addr", bus.gb_wr_addr, exp_addr);
    chk("t2_data", bus.gb_wr_data, 48'h6564_6362_6160);
    step();
    chk("t2_en_done", bus.gb_wr_en, 0);
    chk("t2_busy_done", bus.arb_busy, 0);

    // 3/4: contention and backpressure from a fresh reset
    do_reset();
    n_acc = 0; n_out = 0;
    for (int n = 1; n <= 10; n++) begin
      drive_contention(n);
      chk($sformatf("t3_core_ready_%0d", n), bus.core_ready, (n == 8 || n == 10) ? 1'b0 : 1'b1);
      chk($sformatf("t3_ld_ready_%0d", n), bus.ld_ready, (n % 2 == 1) ? 1'b1 : 1'b0);
      if (!(n == 8 || n == 10)) begin
        acc_q.push_back(n);
        n_acc++;
      end
      step();
      if (n % 2 == 1) begin
        chk($sformatf("t3_en_L_%0d", n), bus.gb_wr_en, 6'b000001);
        chk($sformatf("t3_data_L_%0d", n), bus.gb_wr_data, DW'(8'h80 + n));
      end else begin
        tag = acc_q.pop_front();
        nb = DW'(tag);
        n_out++;
        chk($sformatf("t3_en_C_%0d", n), bus.gb_wr_en, 6'h3f);
        chk($sformatf("t3_data_C_%0d", n), bus.gb_wr_data, {K{nb}});
      end
    end
`ifdef GB_ARB_STATS_EN
    chk("t7_ld_stall", stat_ld_stall, 32'd5);
    chk("t7_core_full", stat_core_full, 32'd2);
    stat_clr = 1'b1;
`endif
    idle_inputs();
    for (int d = 0; d < 3; d++) begin
      step();
`ifdef GB_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      tag = acc_q.pop_front();
      nb = DW'(tag);
      n_out++;
      chk($sformatf("t4_drain_en_%0d", d), bus.gb_wr_en, 6'h3f);
      chk($sformatf("t4_drain_data_%0d", d), bus.gb_wr_data, {K{nb}});
    end
    step();
    chk("t4_drained_en", bus.gb_wr_en, 0);
    chk("t4_drained_busy", bus.arb_busy, 0);
    chk("t4_accepts_total", n_acc, 8);
    chk("t4_outputs_total", n_out, n_acc);
`ifdef GB_ARB_STATS_EN
    chk("t7_clr_stall", stat_ld_stall, 0);
    chk("t7_clr_full", stat_core_full, 0);
`endif

    // 5: address wrap, and base change with an entry queued
    bus.cfg_write_base_addr = 16'hFFFF;
    bus.core_wr_en = 6'h3f;
    bus.core_addr  = lane_addr(16'h0002, 0);
    bus.core_data  = {K{8'hA5}};
    step();
    bus.cfg_write_base_addr = 16'h0000;
    bus.core_data  = {K{8'h5A}};
    step();
    bus.core_wr_en = '0;
    chk("t5_wrap_en", bus.gb_wr_en, 6'h3f);
    chk("t5_wrap_addr", bus.gb_wr_addr, lane_addr(16'h0001, 0));
    step();
    chk("t5_newbase_addr", bus.gb_wr_addr, lane_addr(16'h0002, 0));
    chk("t5_newbase_data", bus.gb_wr_data, {K{8'h5A}});

    // 6: asynchronous reset with three entries queued
    do_reset();
    for (int n = 1; n <= 5; n++) begin
      drive_contention(n);
      step();
    end
    chk("t6_pre_en", bus.gb_wr_en, 6'b000001);
    chk("t6_pre_core_ready", bus.core_ready, 1);
    chk("t6_pre_ld_ready", bus.ld_ready, 0);
    idle_inputs();
    rst_async_n = 1'b0;
    #1;
    chk("t6_rst_en", bus.gb_wr_en, 0);
    chk("t6_rst_busy", bus.arb_busy, 0);
    @(negedge clk);
    rst_async_n = 1'b1;
    step();
    chk("t6_after_en", bus.gb_wr_en, 0);
    chk("t6_after_ld_ready", bus.ld_ready, 1);
    chk("t6_after_core_ready", bus.core_ready, 1);
    step();
    chk("t6_after2_en", bus.gb_wr_en, 0);
    chk("t6_after2_busy", bus.arb_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
